vec_dist_unit: RTL and testbench
================================

# vec_dist_unit

Sequential vector-distance engine for the GAM datapath. It accepts two packed unsigned vectors of VECTOR_LEN elements and accumulates the squared element differences one element per cycle. Depending on the captured mode, it returns either the sum of squared differences or its floor integer square root (Euclidean distance), computed bit-serially. It sits downstream of the vector registers and replaces the combinational subtract/square/adder/sqrt chain with a handshaked, pipelined-by-FSM unit.

## Interface
- ELEM_WIDTH, 8: element width in bits; elements are unsigned.
- VECTOR_LEN, 4: number of elements per vector; must be ≥ 1.
- ACC_W, 2*ELEM_WIDTH + $clog2(VECTOR_LEN): accumulator and result width. This is derived and must not be overridden.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept a transaction.
- vec_a  in  VECTOR_LEN*ELEM_WIDTH  element i at [i*ELEM_WIDTH +: ELEM_WIDTH].
- vec_b  in  VECTOR_LEN*ELEM_WIDTH  same packing as vec_a.
- mode  in  1  0 = sum of squared differences, 1 = floor(sqrt(sum)).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  ACC_W  sum or root; the root is zero-extended.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ACCUM, SQRT and DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready at an edge, capture vec_a, vec_b and mode, clear acc and idx, and go to ACCUM.
- ACCUM: each edge adds |a[idx]-b[idx]|² to acc, where the difference is ELEM_WIDTH bits and the square is 2*ELEM_WIDTH bits, then increments idx.
  - On the edge that adds element VECTOR_LEN-1, go to DONE with result=final sum if mode=0.
  - Otherwise go to SQRT, loading the radicand with the final sum.
- SQRT: digit-by-digit restoring root, producing one root bit per edge, MSB first, over R = (ACC_W+1)/2 edges.
  - On the R-th edge, go to DONE with result = floor(sqrt(sum)).
- DONE: out_valid=1, and result is held stable.
  - On an edge with out_ready=1, go to IDLE. out_valid falls after that edge.
- Arithmetic: acc cannot overflow by construction, since VECTOR_LEN*(2^ELEM_WIDTH-1)² < 2^ACC_W. No saturation logic.
- in_valid is ignored outside IDLE, and captured operands are unaffected by later input changes.
- mode is sampled only at acceptance.
- When VECTOR_LEN=1, ACCUM lasts exactly one edge.

## Timing
- Reset (rst high at an edge) forces IDLE from any state, including mid-ACCUM or mid-SQRT. The in-flight transaction is discarded.
  - Outputs after the reset edge: in_ready=1, out_valid=0, busy=0, result=0.
  - acc, idx and root registers are cleared.
- Latency: let E0 be the acceptance edge.
  - mode 0: out_valid goes high after edge E0+VECTOR_LEN.
  - mode 1: out_valid goes high after edge E0+VECTOR_LEN+R.
- Throughput: one transaction in flight. The earliest next acceptance is the edge after the out_valid&out_ready edge. With out_ready tied high, mode 0 accepts every VECTOR_LEN+2 cycles.
- in_ready and out_valid are never high simultaneously.
- No combinational path exists from in_valid or out_ready to any output. All outputs are registered or decoded from state.
- For the defaults (ELEM_WIDTH=8, VECTOR_LEN=4): ACC_W=18, R=9.
  - mode 0 latency is 4 cycles.
  - mode 1 latency is 13 cycles.

## Test plan
- a={1,2,3,4}, b={4,6,3,0} (element 0 first):
  - mode 0 gives result=41 with out_valid exactly 4 cycles after acceptance.
  - mode 1 gives result=6 at 13 cycles.
- Max operands, a all 255 and b all 0:
  - mode 0 gives 260100 (no overflow in 18 bits).
  - mode 1 gives 510.
- vec_a==vec_b: result=0 in both modes.
- a={3,0,0,0}, b={0,4,0,0}:
  - mode 1 gives 5.
  - Back-to-back with out_ready=1, the second transaction is accepted on the edge after the first handshake and gives the correct result.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - result stays stable and out_valid stays high.
  - in_ready=0 throughout, and a pulsed in_valid with new operands is ignored.
  - After out_ready rises, the unit returns to IDLE with in_ready=1.
- Reset: assert rst for one cycle at the 3rd SQRT cycle.
  - The next cycle shows out_valid=0, result=0, in_ready=1, busy=0, and no stale result ever appears.
  - The following mode 1 transaction with a={1,2,3,4}, b={4,6,3,0} returns 6.

Source files
------------

// File: rtl/vec_dist_if.sv
// Handshake bundle for vec_dist_unit: operand request channel, result channel and busy flag.
// ACC_W is derived from the element geometry so that both ends always agree on the result width.
interface vec_dist_if #(
    parameter int ELEM_WIDTH = 8,
    parameter int VECTOR_LEN = 4
);
    localparam int ACC_W = 2 * ELEM_WIDTH + $clog2(VECTOR_LEN);

    logic                             in_valid;
    logic                             in_ready;
    logic [VECTOR_LEN*ELEM_WIDTH-1:0] vec_a;
    logic [VECTOR_LEN*ELEM_WIDTH-1:0] vec_b;
    logic                             mode;
    logic                             out_valid;
    logic                             out_ready;
    logic [ACC_W-1:0]                 result;
    logic                             busy;

    modport master (
        output in_valid, vec_a, vec_b, mode, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, vec_a, vec_b, mode, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/vec_dist_unit.sv
// Sequential vector-distance engine: accumulates squared element differences one per cycle,
// then optionally takes a bit-serial restoring integer square root of the sum.
module vec_dist_unit #(
    parameter int ELEM_WIDTH = 8,
    parameter int VECTOR_LEN = 4
) (
    input logic      clk,
    input logic      rst,
    vec_dist_if.slave bus
);
    localparam int ACC_W = 2 * ELEM_WIDTH + $clog2(VECTOR_LEN);
    localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam int R     = (ACC_W + 1) / 2;
    localparam int RAD_W = 2 * R;
    localparam int REM_W = R + 2;
    localparam int CNT_W = $clog2(R + 1);
    localparam int VEC_W = VECTOR_LEN * ELEM_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, SQRT, DONE} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [R-1:0]       root_q, root_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               in_ready_q, out_valid_q, busy_q;

    logic [ELEM_WIDTH-1:0]   a_el, b_el, diff;
    logic [2*ELEM_WIDTH-1:0] sq;
    logic [ACC_W-1:0]        acc_sum;
    logic [REM_W-1:0]        rem_shift, trial, rem_step;
    logic [R-1:0]            root_step;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        a_el    = a_q[idx_q*ELEM_WIDTH +: ELEM_WIDTH];
        b_el    = b_q[idx_q*ELEM_WIDTH +: ELEM_WIDTH];
        diff    = (a_el >= b_el) ? (a_el - b_el) : (b_el - a_el);
        sq      = {{ELEM_WIDTH{1'b0}}, diff} * {{ELEM_WIDTH{1'b0}}, diff};
        acc_sum = acc_q + ACC_W'(sq);

        // One restoring-root digit: bring down two radicand bits, try subtracting 4*root+1.
        rem_shift = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
        trial     = {root_q, 2'b01};
        if (rem_shift >= trial) begin
            rem_step  = rem_shift - trial;
            root_step = (root_q << 1) | R'(1);
        end else begin
            rem_step  = rem_shift;
            root_step = root_q << 1;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.vec_a;
                    b_d     = bus.vec_b;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(VECTOR_LEN - 1)) begin
                    if (!mode_q) begin
                        result_d = acc_sum;
                        state_d  = DONE;
                    end else begin
                        rad_d   = RAD_W'(acc_sum);
                        rem_d   = '0;
                        root_d  = '0;
                        cnt_d   = '0;
                        state_d = SQRT;
                    end
                end
            end
            SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_step;
                root_d = root_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(R - 1)) begin
                    result_d = ACC_W'(root_step);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_vec_dist_unit.sv
// Directed self-checking bench for vec_dist_unit with hand-computed distances and latencies.
module tb_vec_dist_unit;
    localparam int EW = 8;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   lat;
    int   seen;

    always #5 clk = ~clk;

    vec_dist_if #(.ELEM_WIDTH(EW), .VECTOR_LEN(VL)) bus ();

    vec_dist_unit #(.ELEM_WIDTH(EW), .VECTOR_LEN(VL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    // Called on a negedge; returns on the negedge just after the acceptance edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic m);
        int waitCnt = 0;
        while (!bus.in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        bus.vec_a    = a;
        bus.vec_b    = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runTxn(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input int expRes, input int expLat);
        int l;
        applyStimulus(a, b, m);
        waitResult(l);
        checkOutput({tag, "_lat"}, l, expLat);
        checkOutput({tag, "_res"}, bus.result, expRes);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a1, b1, amax, zero, pa, pb;
        a1   = pack4(1, 2, 3, 4);
        b1   = pack4(4, 6, 3, 0);
        amax = pack4(255, 255, 255, 255);
        zero = '0;
        pa   = pack4(3, 0, 0, 0);
        pb   = pack4(0, 4, 0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.vec_a     = '0;
        bus.vec_b     = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_result", bus.result, 0);
        rst = 1'b0;
        @(negedge clk);

        runTxn("basic_m0", a1, b1, 1'b0, 41, 4);
        runTxn("basic_m1", a1, b1, 1'b1, 6, 13);
        runTxn("max_m0", amax, zero, 1'b0, 260100, 4);
        runTxn("max_m1", amax, zero, 1'b1, 510, 13);
        runTxn("eq_m0", a1, a1, 1'b0, 0, 4);
        runTxn("eq_m1", a1, a1, 1'b1, 0, 13);
        runTxn("pyth_m1", pa, pb, 1'b1, 5, 13);

        // Back-to-back: request held across the handshake edge, accepted on the following edge.
        applyStimulus(pa, pb, 1'b1);
        waitResult(lat);
        checkOutput("b2b_first_res", bus.result, 5);
        checkOutput("b2b_in_ready_in_done", bus.in_ready, 0);
        bus.vec_a    = a1;
        bus.vec_b    = b1;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_idle_ready", bus.in_ready, 1);
        checkOutput("b2b_idle_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("b2b_accepted_busy", bus.busy, 1);
        waitResult(lat);
        checkOutput("b2b_second_lat", lat, 4);
        checkOutput("b2b_second_res", bus.result, 41);
        @(negedge clk);

        // Backpressure with an ignored request pulse while DONE.
        bus.out_ready = 1'b0;
        applyStimulus(a1, b1, 1'b0);
        waitResult(lat);
        checkOutput("bp_res", bus.result, 41);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.vec_a    = amax;
                bus.vec_b    = zero;
                bus.mode     = 1'b1;
                bus.in_valid = 1'b1;
            end
            if (i == 2) bus.in_valid = 1'b0;
            @(negedge clk);
            checkOutput("bp_hold_valid", bus.out_valid, 1);
            checkOutput("bp_hold_res", bus.result, 41);
            checkOutput("bp_hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", bus.in_ready, 1);
        checkOutput("bp_release_valid", bus.out_valid, 0);
        checkOutput("bp_release_busy", bus.busy, 0);
        @(negedge clk);

        // Reset landing on the third SQRT edge (acceptance edge + 7).
        applyStimulus(a1, b1, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("mid_sqrt_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_result", bus.result, 0);
        checkOutput("mid_rst_ready", bus.in_ready, 1);
        checkOutput("mid_rst_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen++;
        end
        checkOutput("mid_rst_no_stale", seen, 0);
        runTxn("after_rst_m1", a1, b1, 1'b1, 6, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
